// File: rtl/demux_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : demux_fifo2
// Purpose  : Streaming 1-to-2 demultiplexer. Each accepted word is routed by
//            in_sel into one of two independent DEPTH-entry FIFOs, each with
//            its own valid/ready output handshake.
// Ports    : clk, rst_n (async, active low)
//            in_data/in_sel/in_valid -> in_ready   producer side
//            out1_data/out1_valid/out1_count <- out1_ready   consumer 1
//            out2_data/out2_valid/out2_count <- out2_ready   consumer 2
//            stat1_words/stat2_words/stat_stall  (DEMUX_FIFO2_STATS_EN only)
// Options  : `define DEMUX_FIFO2_STATS_EN adds push and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module demux_fifo2 #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out1_data,
    output logic                   out1_valid,
    input  logic                   out1_ready,
    output logic [WIDTH-1:0]       out2_data,
    output logic                   out2_valid,
    input  logic                   out2_ready,
    output logic [$clog2(DEPTH):0] out1_count,
`ifdef DEMUX_FIFO2_STATS_EN
    output logic [31:0]            stat1_words,
    output logic [31:0]            stat2_words,
    output logic [31:0]            stat_stall,
`endif
    output logic [$clog2(DEPTH):0] out2_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    logic [1:0]         w_sel_hot;
    logic [1:0]         w_out_ready;
    logic [1:0]         w_full;
    logic [1:0]         w_valid;
    logic [1:0]         w_push;
    logic [WIDTH-1:0]   w_data  [2];
    logic [c_cnt_w-1:0] w_count [2];

    assign w_sel_hot   = {in_sel, ~in_sel};
    assign w_out_ready = {out2_ready, out1_ready};

    // Readiness looks only at the addressed FIFO; a pop on the same edge
    // does not open a slot for the push.
    assign in_ready = rst_n & (in_sel ? ~w_full[1] : ~w_full[0]);

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [WIDTH-1:0]   r_mem [DEPTH];
        logic [c_ptr_w-1:0] r_rd;
        logic [c_ptr_w-1:0] r_wr;
        logic [c_cnt_w-1:0] r_cnt;
        logic [WIDTH-1:0]   r_head;
        logic               w_pop;
        logic [c_ptr_w-1:0] w_rd_nxt;
        logic [WIDTH-1:0]   w_head_nxt;

        assign w_full[g]  = (r_cnt == c_cnt_full);
        assign w_valid[g] = (r_cnt != '0);
        assign w_push[g]  = in_valid & in_ready & w_sel_hot[g];
        assign w_pop      = w_valid[g] & w_out_ready[g];
        assign w_rd_nxt   = w_pop ? (r_rd + c_ptr_one) : r_rd;

        // The head register tracks storage[rd_ptr] one edge ahead so the
        // output is a flop, not a mux of flops. When the slot being written
        // is the next head (FIFO empty after this edge's pop), take in_data.
        assign w_head_nxt = (w_push[g] && (r_wr == w_rd_nxt)) ? in_data
                                                               : r_mem[w_rd_nxt];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
                r_rd   <= '0;
                r_wr   <= '0;
                r_cnt  <= '0;
                r_head <= '0;
            end else begin
                if (w_push[g]) begin
                    r_mem[r_wr] <= in_data;
                    r_wr        <= r_wr + c_ptr_one;
                end
                r_rd   <= w_rd_nxt;
                r_head <= w_head_nxt;
                case ({w_push[g], w_pop})
                    2'b10:   r_cnt <= r_cnt + c_cnt_one;
                    2'b01:   r_cnt <= r_cnt - c_cnt_one;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        assign w_data[g]  = r_head;
        assign w_count[g] = r_cnt;
    end

    assign out1_data  = w_data[0];
    assign out1_valid = w_valid[0];
    assign out1_count = w_count[0];
    assign out2_data  = w_data[1];
    assign out2_valid = w_valid[1];
    assign out2_count = w_count[1];

`ifdef DEMUX_FIFO2_STATS_EN
    logic [31:0] r_stat1;
    logic [31:0] r_stat2;
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat1 <= '0;
            r_stat2 <= '0;
            r_stall <= '0;
        end else begin
            if (w_push[0]) r_stat1 <= r_stat1 + 32'd1;
            if (w_push[1]) r_stat2 <= r_stat2 + 32'd1;
            if (in_valid && !in_ready) r_stall <= r_stall + 32'd1;
        end
    end

    assign stat1_words = r_stat1;
    assign stat2_words = r_stat2;
    assign stat_stall  = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_fifo2
// Purpose  : Self-checking bench for demux_fifo2 (WIDTH=64, DEPTH=2).
//            Table-driven directed vectors, hand-written reset and wrap
//            sequences, and a randomized run against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_fifo2;

    localparam int WIDTH = 64;
    localparam int DEPTH = 2;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  out1_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [WIDTH-1:0]  out2_data;
    logic              out2_valid;
    logic              out2_ready;
    logic [1:0]        out1_count;
    logic [1:0]        out2_count;
`ifdef DEMUX_FIFO2_STATS_EN
    logic [31:0]       stat1_words;
    logic [31:0]       stat2_words;
    logic [31:0]       stat_stall;
`endif

    demux_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out1_count (out1_count),
`ifdef DEMUX_FIFO2_STATS_EN
        .stat1_words(stat1_words),
        .stat2_words(stat2_words),
        .stat_stall (stat_stall),
`endif
        .out2_count (out2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model: plain queues per output, bounded at DEPTH.
    logic [WIDTH-1:0] q1 [$];
    logic [WIDTH-1:0] q2 [$];
    int exp_s1, exp_s2, exp_stall;

    typedef struct {
        logic             v;
        logic             s;
        logic [WIDTH-1:0] d;
        logic             r1;
        logic             r2;
        logic             e_rdy;
        logic             e_v1;
        logic [WIDTH-1:0] e_d1;
        int               e_c1;
        logic             e_v2;
        logic [WIDTH-1:0] e_d2;
        int               e_c2;
    } vec_t;

    vec_t alt_tbl  [5];
    vec_t fill_tbl [7];

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q1.delete();
        q2.delete();
        exp_s1 = 0;
        exp_s2 = 0;
        exp_stall = 0;
    endtask

    // Called at posedge+1: drive, check pre-edge state against the model,
    // advance the model across the edge, return at the next posedge+1.
    task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic r1, input logic r2);
        logic exp_rdy;
        in_valid = v; in_sel = s; in_data = d; out1_ready = r1; out2_ready = r2;
        #1;
        exp_rdy = s ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
        chk("in_ready", in_ready, exp_rdy);
        chk("out1_valid", out1_valid, q1.size() != 0);
        chk("out1_count", out1_count, q1.size());
        if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
        chk("out2_valid", out2_valid, q2.size() != 0);
        chk("out2_count", out2_count, q2.size());
        if (q2.size() != 0) chk("out2_data", out2_data, q2[0]);
        if (q1.size() != 0 && r1) void'(q1.pop_front());
        if (q2.size() != 0 && r2) void'(q2.pop_front());
        if (v && exp_rdy) begin
            if (s) begin q2.push_back(d); exp_s2++; end
            else   begin q1.push_back(d); exp_s1++; end
        end
        if (v && !exp_rdy) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_row(input vec_t r, input string tag);
        in_valid = r.v; in_sel = r.s; in_data = r.d; out1_ready = r.r1; out2_ready = r.r2;
        #1;
        chk({tag, ".in_ready"}, in_ready, r.e_rdy);
        chk({tag, ".out1_valid"}, out1_valid, r.e_v1);
        chk({tag, ".out1_count"}, out1_count, r.e_c1);
        if (r.e_v1) chk({tag, ".out1_data"}, out1_data, r.e_d1);
        chk({tag, ".out2_valid"}, out2_valid, r.e_v2);
        chk({tag, ".out2_count"}, out2_count, r.e_c2);
        if (r.e_v2) chk({tag, ".out2_data"}, out2_data, r.e_d2);
        cycle(r.v, r.s, r.d, r.r1, r.r2);
    endtask

    // Reset asserted away from the clock edge; returns at posedge+1.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        #1;
        chk("rst.in_ready", in_ready, 1'b0);
        chk("rst.out1_valid", out1_valid, 1'b0);
        chk("rst.out2_valid", out2_valid, 1'b0);
        chk("rst.out1_count", out1_count, 0);
        chk("rst.out2_count", out2_count, 0);
        chk("rst.out1_data", out1_data, 0);
        chk("rst.out2_data", out2_data, 0);
`ifdef DEMUX_FIFO2_STATS_EN
        chk("rst.stat1", stat1_words, 0);
        chk("rst.stat_stall", stat_stall, 0);
`endif
        in_valid = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic             hv, hs, held;
        logic [WIDTH-1:0] hd;
        logic             rr1, rr2;

        n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out1_ready = 1'b0; out2_ready = 1'b0;
        model_clear();

        //                 v  s  d      r1 r2 rdy v1 d1     c1 v2 d2     c2
        alt_tbl[0] = '{1'b1, 1'b0, 64'hA, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 0, 1'b0, 64'h0, 0};
        alt_tbl[1] = '{1'b1, 1'b1, 64'hB, 1'b1, 1'b1, 1'b1, 1'b1, 64'hA, 1, 1'b0, 64'h0, 0};
        alt_tbl[2] = '{1'b1, 1'b0, 64'hC, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 0, 1'b1, 64'hB, 1};
        alt_tbl[3] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hC, 1, 1'b0, 64'h0, 0};
        alt_tbl[4] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 0, 1'b0, 64'h0, 0};

        fill_tbl[0] = '{1'b1, 1'b0, 64'h1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 0, 1'b0, 64'h0, 0};
        fill_tbl[1] = '{1'b1, 1'b0, 64'h2, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1, 1, 1'b0, 64'h0, 0};
        fill_tbl[2] = '{1'b1, 1'b1, 64'h3, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1, 2, 1'b0, 64'h0, 0};
        fill_tbl[3] = '{1'b1, 1'b0, 64'h4, 1'b1, 1'b1, 1'b0, 1'b1, 64'h1, 2, 1'b1, 64'h3, 1};
        fill_tbl[4] = '{1'b1, 1'b0, 64'h4, 1'b1, 1'b1, 1'b1, 1'b1, 64'h2, 1, 1'b0, 64'h0, 0};
        fill_tbl[5] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h4, 1, 1'b0, 64'h0, 0};
        fill_tbl[6] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 0, 1'b0, 64'h0, 0};

        // Reset then idle.
        #1;
        in_valid = 1'b1;
        #1;
        chk("por.in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        in_sel = 1'b0;
        #1;
        chk("idle.in_ready_sel0", in_ready, 1'b1);
        in_sel = 1'b1;
        #1;
        chk("idle.in_ready_sel1", in_ready, 1'b1);
        chk("idle.out1_valid", out1_valid, 1'b0);
        chk("idle.out2_valid", out2_valid, 1'b0);
        chk("idle.out1_count", out1_count, 0);
        chk("idle.out2_count", out2_count, 0);
        chk("idle.out1_data", out1_data, 0);
        chk("idle.out2_data", out2_data, 0);
        @(posedge clk);
        #1;

        // Alternating routing with consumers always ready.
        for (int i = 0; i < 5; i++) apply_row(alt_tbl[i], $sformatf("alt%0d", i));

        // Fill and backpressure, starting from a fresh reset.
        do_reset();
        for (int i = 0; i < 7; i++) apply_row(fill_tbl[i], $sformatf("fill%0d", i));
`ifdef DEMUX_FIFO2_STATS_EN
        chk("stats.stat1_words", stat1_words, 32'd3);
        chk("stats.stat2_words", stat2_words, 32'd1);
        chk("stats.stat_stall", stat_stall, 32'd1);
`endif

        // Streaming through FIFO 2 with simultaneous push/pop and wrap.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sel = 1'b1; in_data = 64'h10 + 64'(i);
            out1_ready = 1'b1; out2_ready = 1'b1;
            #1;
            if (i > 0) begin
                chk("wrap.out2_count", out2_count, 1);
                chk("wrap.out2_data", out2_data, 64'h10 + 64'(i - 1));
            end
            cycle(1'b1, 1'b1, 64'h10 + 64'(i), 1'b1, 1'b1);
        end
        in_valid = 1'b0;
        #1;
        chk("wrap.last_data", out2_data, 64'h17);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Reset mid-operation with two words queued in each FIFO.
        cycle(1'b1, 1'b0, 64'hD1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'hD2, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 64'hD3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'hD4, 1'b0, 1'b0);
        chk("pre_rst.out1_count", out1_count, 2);
        chk("pre_rst.out2_count", out2_count, 2);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Randomized traffic; producer holds a stalled word stable.
        held = 1'b0; hv = 1'b0; hs = 1'b0; hd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!held) begin
                hv = ($urandom_range(0, 3) != 0);
                hs = 1'($urandom_range(0, 1));
                hd = {$urandom, $urandom};
            end
            if (i < 300) begin
                rr1 = ($urandom_range(0, 2) == 0);
                rr2 = ($urandom_range(0, 2) == 0);
            end else begin
                rr1 = ($urandom_range(0, 3) != 0);
                rr2 = ($urandom_range(0, 3) != 0);
            end
            held = hv && (hs ? (q2.size() >= DEPTH) : (q1.size() >= DEPTH));
            cycle(hv, hs, hd, rr1, rr2);
        end
`ifdef DEMUX_FIFO2_STATS_EN
        chk("rand.stat1_words", stat1_words, 32'(exp_s1));
        chk("rand.stat2_words", stat2_words, 32'(exp_s2));
        chk("rand.stat_stall", stat_stall, 32'(exp_stall));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
